// File: rtl/grant_pkg.sv
// grant_pkg: shared state encoding, default parameters and counter width helper
package grant_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, COOL} grant_state_t;
    localparam int N_OUT_DEF    = 4;
    localparam int HOLD_MAX_DEF = 15;
    localparam int GAP_DEF      = 1;
    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction
    localparam int HOLD_W_DEF = cnt_w(HOLD_MAX_DEF);
    localparam int GAP_W_DEF  = cnt_w(GAP_DEF);
endpackage

// File: rtl/grant_hold_counter.sv
// grant_hold_counter: clearable up-counter flagging when it sits on the terminal count
module grant_hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end
    assign done_o = (cnt_q == tc_i);
endmodule

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder: accepts an encoded index over valid/ready and drives a registered
// one-hot grant, held until release or hold timeout, followed by a cooldown gap
module onehot_grant_decoder
    import grant_pkg::*;
#(
    parameter int N_OUT    = N_OUT_DEF,
    parameter int IDX_W    = $clog2(N_OUT),
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int GAP      = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] a_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             release_i,
    output logic [N_OUT-1:0] y_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             err_o
);
    localparam int HW = cnt_w(HOLD_MAX);
    localparam int GW = cnt_w(GAP);
    localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_MAX - 1);
    localparam logic [GW-1:0] GAP_TC  = GW'((GAP > 0) ? GAP - 1 : 0);

    grant_state_t     state_q, state_d;
    logic [N_OUT-1:0] y_q, y_d;
    logic             ready_q, busy_q, timeout_q, timeout_d, err_q, err_d;
    logic             hold_done, gap_done, idx_ok;

    grant_hold_counter #(.W(HW)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != GRANT),
        .en_i   (state_q == GRANT),
        .tc_i   (HOLD_TC),
        .done_o (hold_done)
    );

    grant_hold_counter #(.W(GW)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != COOL),
        .en_i   (state_q == COOL),
        .tc_i   (GAP_TC),
        .done_o (gap_done)
    );

    assign idx_ok = int'(a_i) < N_OUT;

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    if (idx_ok) begin
                        y_d     = N_OUT'(1) << a_i;
                        state_d = GRANT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                // release takes precedence over expiry, so no timeout when both coincide
                if (release_i || hold_done) begin
                    y_d       = '0;
                    timeout_d = !release_i;
                    state_d   = (GAP == 0) ? IDLE : COOL;
                end
            end
            COOL: state_d = gap_done ? IDLE : COOL;
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign y_o       = y_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb_onehot_grant_decoder: directed vectors with hand-computed expectations for the grant decoder
module tb_onehot_grant_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a;
    logic       valid, rel;
    logic       ready, busy, timeout, err;
    logic [3:0] y;
    int         n_cmp = 0;
    int         n_err = 0;

    onehot_grant_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .a_i       (a),
        .valid_i   (valid),
        .ready_o   (ready),
        .release_i (rel),
        .y_o       (y),
        .busy_o    (busy),
        .timeout_o (timeout),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".y"}, 32'(y), 32'h0);
        chk({tag, ".ready"}, 32'(ready), 32'h1);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; a = 2'd2; rel = 1'b0;
        tick(); tick(); tick();
        chk_idle("rst_hold");
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        valid = 1'b0; rst = 1'b0;
        tick();
        chk_idle("post_rst");

        // release during the third grant cycle
        valid = 1'b1; a = 2'd2;
        tick(); valid = 1'b0;
        chk("t2_g1_y", 32'(y), 32'h4);
        chk("t2_g1_ready", 32'(ready), 32'h0);
        chk("t2_g1_busy", 32'(busy), 32'h1);
        tick();
        chk("t2_g2_y", 32'(y), 32'h4);
        tick();
        chk("t2_g3_y", 32'(y), 32'h4);
        rel = 1'b1;
        tick(); rel = 1'b0;
        chk("t2_cool_y", 32'(y), 32'h0);
        chk("t2_cool_ready", 32'(ready), 32'h0);
        chk("t2_cool_busy", 32'(busy), 32'h1);
        tick();
        chk_idle("t2_idle");

        // no release: grant expires after 15 cycles
        valid = 1'b1; a = 2'd3;
        tick(); valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t3_hold%0d_y", i), 32'(y), 32'h8);
            chk($sformatf("t3_hold%0d_to", i), 32'(timeout), 32'h0);
            tick();
        end
        chk("t3_drop_y", 32'(y), 32'h0);
        chk("t3_drop_to", 32'(timeout), 32'h1);
        chk("t3_drop_busy", 32'(busy), 32'h1);
        tick();
        chk("t3_to_once", 32'(timeout), 32'h0);
        chk_idle("t3_idle");

        // release coincides with the last hold cycle: no timeout
        valid = 1'b1; a = 2'd1;
        tick(); valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("t4_hold%0d_y", i), 32'(y), 32'h2);
            tick();
        end
        chk("t4_last_y", 32'(y), 32'h2);
        rel = 1'b1;
        tick(); rel = 1'b0;
        chk("t4_drop_y", 32'(y), 32'h0);
        chk("t4_no_to", 32'(timeout), 32'h0);
        tick();
        chk("t4_no_to2", 32'(timeout), 32'h0);
        chk_idle("t4_idle");

        // back-to-back grants, one every three cycles
        valid = 1'b1; rel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 2'(k);
            tick();
            chk($sformatf("t5_g%0d_y", k), 32'(y), 32'h1 << k);
            chk($sformatf("t5_g%0d_ready", k), 32'(ready), 32'h0);
            tick();
            chk($sformatf("t5_c%0d_y", k), 32'(y), 32'h0);
            chk($sformatf("t5_c%0d_ready", k), 32'(ready), 32'h0);
            tick();
            chk($sformatf("t5_i%0d_y", k), 32'(y), 32'h0);
            chk($sformatf("t5_i%0d_ready", k), 32'(ready), 32'h1);
            chk($sformatf("t5_i%0d_to", k), 32'(timeout), 32'h0);
        end
        valid = 1'b0; rel = 1'b0;
        tick();
        chk_idle("t5_end");

        // asynchronous reset in the middle of a grant
        valid = 1'b1; a = 2'd1;
        tick(); valid = 1'b0;
        chk("t6_pre_y", 32'(y), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk_idle("t6_async");
        tick(); rst = 1'b0;
        tick();
        chk_idle("t6_after");
        valid = 1'b1; a = 2'd0;
        tick(); valid = 1'b0;
        chk("t6_regrant_y", 32'(y), 32'h1);
        chk("t6_regrant_err", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
